// File: rtl/dma_defs.sv
// Shared definitions for the OAM DMA engine: FSM encoding, address constants
// and the echo-RAM source fold.
package dma_defs;

  localparam int          OAM_SIZE     = 160;
  localparam logic [7:0]  LAST_INDEX   = 8'(OAM_SIZE - 1);
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  ECHO_BASE    = 8'hE0;
  localparam logic [7:0]  ECHO_FOLD    = 8'h20;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [7:0] index;
  } pipe_entry_t;

  // Pages 0xE0..0xFF mirror work RAM at 0xC0..0xDF.
  function automatic logic [7:0] fold_source(input logic [7:0] value);
    if (value >= ECHO_BASE) begin
      return value - ECHO_FOLD;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/dma_read_pipe.sv
// Shift register that carries the request valid bit and OAM index alongside
// the source read latency, so each returned byte lands with its index.
module dma_read_pipe
  import dma_defs::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       req_valid,
  input  logic [7:0] req_index,
  output logic       wr_valid,
  output logic [7:0] wr_index
);

  pipe_entry_t stage_r [DEPTH];

  // Flush drops every in-flight valid, including the one entering this edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i].valid <= 1'b0;
      end
    end else begin
      stage_r[0] <= '{valid: req_valid, index: req_index};
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign wr_valid = stage_r[DEPTH-1].valid;
  assign wr_index = stage_r[DEPTH-1].index;

endmodule

// File: rtl/oam_dma_engine.sv
// OAM DMA initiator: snoops writes to 0xFF46, reads 160 bytes from {src,00}
// and writes them in order into sprite OAM while holding the CPU off the bus.
module oam_dma_engine
  import dma_defs::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oDmaReg,
  output logic        oDmaBusy,
  output logic        oDmaReadRequest,
  output logic [15:0] oDmaReadAddr,
  input  logic [7:0]  iDmaReadData,
  output logic        oOamWe,
  output logic [7:0]  oOamAddr,
  output logic [7:0]  oOamData
);

  logic [1:0] state_r;
  logic [1:0] state_next_s;
  logic [7:0] src_high_r;
  logic [7:0] count_r;
  logic [7:0] count_next_s;
  logic       trigger_s;
  logic       last_write_s;

  assign trigger_s    = iCpuWe && (iCpuAddr == DMA_REG_ADDR);
  assign last_write_s = oOamWe && (oOamAddr == LAST_INDEX);

  // A trigger restarts the transfer from START whatever state we are in.
  always_comb begin
    state_next_s = state_r;
    if (trigger_s) begin
      state_next_s = ST_START;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_IDLE;
        ST_START: state_next_s = ST_XFER;
        ST_XFER: begin
          if (count_r == LAST_INDEX) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_XFER;
          end
        end
        ST_DRAIN: begin
          if (last_write_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // Index of the request shown next cycle; any entry into XFER starts at 0.
  always_comb begin
    count_next_s = 8'h00;
    if ((state_r == ST_XFER) && (state_next_s == ST_XFER)) begin
      count_next_s = count_r + 8'd1;
    end else begin
      count_next_s = 8'h00;
    end
  end

  // FSM, request counter and registered bus-side outputs.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      state_r         <= ST_IDLE;
      count_r         <= 8'h00;
      oDmaBusy        <= 1'b0;
      oDmaReadRequest <= 1'b0;
      oDmaReadAddr    <= 16'h0000;
    end else begin
      state_r         <= state_next_s;
      count_r         <= count_next_s;
      oDmaBusy        <= (state_next_s != ST_IDLE);
      oDmaReadRequest <= (state_next_s == ST_XFER);
      if (state_next_s == ST_XFER) begin
        oDmaReadAddr <= {src_high_r, count_next_s};
      end else begin
        oDmaReadAddr <= 16'h0000;
      end
    end
  end

  // DMA register readback and folded source page, captured on each trigger.
  always_ff @(posedge iClock) begin
    if (!iReset) begin
      oDmaReg    <= 8'h00;
      src_high_r <= 8'h00;
    end else if (trigger_s) begin
      oDmaReg    <= iCpuData;
      src_high_r <= fold_source(iCpuData);
    end else begin
      oDmaReg    <= oDmaReg;
      src_high_r <= src_high_r;
    end
  end

  dma_read_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_read_pipe (
    .clock    (iClock),
    .reset_n  (iReset),
    .flush    (trigger_s),
    .req_valid(oDmaReadRequest),
    .req_index(count_r),
    .wr_valid (oOamWe),
    .wr_index (oOamAddr)
  );

  assign oOamData = iDmaReadData;

endmodule
